mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter LATENCY, default 4: number of cycles from request acceptance to response; legal range 1..255.
REQ-002 Parameter MEM_DEPTH_LOG2, default 12: log2 of the number of 128-bit blocks in the backing store.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 r  input  1  reset, asynchronous, active-low.
REQ-005 cache2mem_valid  input  1  cache request present.
REQ-006 cache2mem_rw  input  1  request type: 0 = block read (allocate), 1 = block write (write-back).
REQ-007 cache2mem_addr  input  32  byte address; block index = addr[MEM_DEPTH_LOG2+3:4].
REQ-008 cache2mem_data  input  128  write-back block; bits 127:96 are word 0, bits 31:0 are word 3.
REQ-009 mem2cache_ready  output  1  one-cycle completion pulse.
REQ-010 mem2cache_data  output  128  read block, same word ordering as cache2mem_data.
REQ-011 mem_busy  output  1  high while a request is accepted but not yet completed.

Function
REQ-012 FSM states: IDLE, ACCESS, RESP; state held in a register.
REQ-013 IDLE: on a rising edge with cache2mem_valid=1, latch addr, rw and data, load the countdown to LATENCY-1, and go to ACCESS; otherwise stay in IDLE.
REQ-014 ACCESS: on each edge, if the countdown is 0, go to RESP; otherwise decrement it.
REQ-015 Transition ACCESS->RESP, read: register the addressed block into mem2cache_data on that edge.
REQ-016 Transition ACCESS->RESP, write: commit the latched block to the array on that edge; mem2cache_data is unchanged.
REQ-017 RESP: mem2cache_ready=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-018 Latency: ready is high in the cycle that begins LATENCY edges after the acceptance edge.
REQ-019 Minimum spacing between acceptances: LATENCY+2 edges; continuous valid=1 yields back-to-back requests at that rate.
REQ-020 Inputs are sampled only at the acceptance edge; changes or a drop of valid during ACCESS/RESP are ignored, and the request completes.
REQ-021 mem2cache_data holds the most recent read block until the next read completes.
REQ-022 mem_busy = 1 in ACCESS and RESP; mem_busy = 0 in IDLE.
REQ-023 addr[3:0] and addr[31:MEM_DEPTH_LOG2+4] are ignored; addresses alias modulo the store size.
REQ-024 A read immediately following a write to the same block returns the newly written data.
REQ-025 mem2cache_ready and mem_busy are driven from registered state only, with no combinational path from inputs.

Reset
REQ-026 r=0 immediately forces the following: state IDLE, countdown 0, mem2cache_ready 0, mem_busy 0, mem2cache_data all zeros.
REQ-027 Reset mid-request aborts it; a write not yet committed is never committed, and no ready pulse is produced.
REQ-028 Backing-store contents are not affected by reset and are retained across it.
REQ-029 The first acceptance is possible on the first rising edge after r rises.

Verification
REQ-030 LATENCY=4: write addr 0x0000_0010, data 0x11111111_22222222_33333333_44444444 -> ready high 4 cycles after acceptance, for one cycle; mem2cache_data stays at 0.
REQ-031 Read addr 0x0000_001C after REQ-030 -> ready pulse, and mem2cache_data = 0x11111111_22222222_33333333_44444444 (offset bits are ignored).
REQ-032 valid held at 1 for 20 cycles as read requests -> acceptances every 6 edges, and exactly one ready per acceptance.
REQ-033 Write issued, then r=0 two cycles after acceptance, then a read of the same block -> no ready from the write, and the old contents are returned.
REQ-034 MEM_DEPTH_LOG2=12: write 0x0001_0020, then read 0x0000_0020 -> aliased data is returned; addr and data toggled during ACCESS have no effect.
REQ-035 LATENCY=1 with back-to-back write then read of the same block -> the read returns the write data, and mem_busy falls to 0 in each IDLE cycle.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Cache-to-memory block transfer bus: one request per transaction, one-cycle completion pulse.
interface mem_ctrl_if;
    logic         cache2mem_valid;
    logic         cache2mem_rw;
    logic [31:0]  cache2mem_addr;
    logic [127:0] cache2mem_data;
    logic         mem2cache_ready;
    logic [127:0] mem2cache_data;
    logic         mem_busy;

    modport master (
        output cache2mem_valid, cache2mem_rw, cache2mem_addr, cache2mem_data,
        input  mem2cache_ready, mem2cache_data, mem_busy
    );

    modport slave (
        input  cache2mem_valid, cache2mem_rw, cache2mem_addr, cache2mem_data,
        output mem2cache_ready, mem2cache_data, mem_busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Fixed-latency block memory behind a cache: accepts one 128-bit read or write-back at a time
// and answers with a single-cycle ready pulse LATENCY edges after acceptance.
module mem_ctrl #(
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned MEM_DEPTH_LOG2 = 12
) (
    input logic        clk,
    input logic        r,
    mem_ctrl_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                    state;
    logic [7:0]                count;
    logic                      rw_q;
    logic [MEM_DEPTH_LOG2-1:0] idx_q;
    logic [127:0]              wdata_q;
    logic [127:0]              mem [DEPTH];
    logic                      commit;

    // Offset and high address bits select nothing; the store aliases modulo its size.
    logic unused_addr;
    assign unused_addr = ^{bus.cache2mem_addr[31:MEM_DEPTH_LOG2+4], bus.cache2mem_addr[3:0]};

    assign commit = (state == ACCESS) && (count == 8'd0);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state               <= IDLE;
            count               <= '0;
            rw_q                <= 1'b0;
            idx_q               <= '0;
            wdata_q             <= '0;
            bus.mem2cache_ready <= 1'b0;
            bus.mem_busy        <= 1'b0;
            bus.mem2cache_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cache2mem_valid) begin
                        rw_q         <= bus.cache2mem_rw;
                        idx_q        <= bus.cache2mem_addr[MEM_DEPTH_LOG2+3:4];
                        wdata_q      <= bus.cache2mem_data;
                        count        <= 8'(LATENCY - 1);
                        bus.mem_busy <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == 8'd0) begin
                        bus.mem2cache_ready <= 1'b1;
                        state               <= RESP;
                        if (!rw_q) begin
                            bus.mem2cache_data <= mem[idx_q];
                        end
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                RESP: begin
                    bus.mem2cache_ready <= 1'b0;
                    bus.mem_busy        <= 1'b0;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the store has no reset so it maps onto RAM; an aborted write never commits
    // because reset forces the FSM out of ACCESS before the commit edge.
    always_ff @(posedge clk) begin
        if (commit && rw_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed-plus-random bench for mem_ctrl at LATENCY=4 and LATENCY=1, checked against
// a block-indexed associative-array model of the backing store.
module tb_mem_ctrl;

    localparam int LAT4 = 4;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic r   = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl_if bus4 ();
    mem_ctrl_if bus1 ();

    mem_ctrl #(.LATENCY(LAT4), .MEM_DEPTH_LOG2(12)) dut4 (.clk(clk), .r(r), .bus(bus4.slave));
    mem_ctrl #(.LATENCY(LAT1), .MEM_DEPTH_LOG2(12)) dut1 (.clk(clk), .r(r), .bus(bus1.slave));

    int checks   = 0;
    int failures = 0;

    logic [127:0] model [int];
    logic [127:0] last4 = '0;
    logic [31:0]  written [$];

    localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;

    function automatic int blk(input logic [31:0] a);
        return int'((a >> 4) % 4096);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=4 instance, starting from an IDLE cycle at a negedge.
    task automatic req4(input logic rw, input logic [31:0] addr, input logic [127:0] data,
                        input bit scramble, input string tag);
        int lat;
        bit got;
        bus4.cache2mem_valid = 1'b1;
        bus4.cache2mem_rw    = rw;
        bus4.cache2mem_addr  = addr;
        bus4.cache2mem_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus4.cache2mem_valid = 1'b0;
        if (scramble) begin
            bus4.cache2mem_rw   = ~rw;
            bus4.cache2mem_addr = $urandom();
            bus4.cache2mem_data = rnd128();
        end
        check({tag, "_busy"}, 128'(bus4.mem_busy), 128'(1));
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= LAT4 + 4 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.mem2cache_ready) begin
                got = 1'b1;
                lat = k;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(LAT4));
        if (rw) model[blk(addr)] = data;
        else    last4 = model[blk(addr)];
        check({tag, "_data"}, bus4.mem2cache_data, last4);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready_once"}, 128'(bus4.mem2cache_ready), 128'(0));
        check({tag, "_idle_busy"}, 128'(bus4.mem_busy), 128'(0));
    endtask

    initial begin
        logic [31:0]  rdy_v, acc_v, busy_v, exp_rdy, exp_acc, exp_busy;
        logic         prev_busy;
        int           next_ok, pulses;
        logic [127:0] d_old, d_new, d3;
        logic [31:0]  a;

        bus4.cache2mem_valid = 1'b0; bus4.cache2mem_rw = 1'b0;
        bus4.cache2mem_addr  = '0;   bus4.cache2mem_data = '0;
        bus1.cache2mem_valid = 1'b0; bus1.cache2mem_rw = 1'b0;
        bus1.cache2mem_addr  = '0;   bus1.cache2mem_data = '0;

        // Reset state
        #1;
        check("rst_ready",  128'(bus4.mem2cache_ready), 128'(0));
        check("rst_busy",   128'(bus4.mem_busy), 128'(0));
        check("rst_data",   bus4.mem2cache_data, '0);
        check("rst1_busy",  128'(bus1.mem_busy), 128'(0));
        repeat (2) @(negedge clk);
        r = 1'b1;

        // First acceptance right after reset release; write leaves read data at zero
        req4(1'b1, 32'h0000_0010, D1, 1'b0, "wr_0x10");
        req4(1'b0, 32'h0000_001C, '0, 1'b0, "rd_0x1C");

        // Aliasing with inputs toggled during ACCESS
        d_new = rnd128();
        req4(1'b1, 32'h0001_0020, d_new, 1'b1, "wr_alias");
        req4(1'b0, 32'h0000_0020, '0, 1'b1, "rd_alias");
        written.push_back(32'h0000_0010);
        written.push_back(32'h0000_0020);

        // Random traffic
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1) == 1) begin
                a = $urandom();
                written.push_back(a);
                req4(1'b1, a, rnd128(), 1'b1, "rand_wr");
            end else begin
                a = written[$urandom_range(written.size() - 1)];
                a = ($urandom() & 32'hFFFF_000F) | (a & 32'h0000_FFF0);
                req4(1'b0, a, '0, 1'b1, "rand_rd");
            end
        end

        // Continuous valid: acceptance spacing and one ready per acceptance
        rdy_v = '0; acc_v = '0; exp_rdy = '0; exp_acc = '0;
        prev_busy = bus4.mem_busy;
        bus4.cache2mem_valid = 1'b1;
        bus4.cache2mem_rw    = 1'b0;
        bus4.cache2mem_addr  = 32'h0000_0010;
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk);
            @(negedge clk);
            rdy_v[e] = bus4.mem2cache_ready;
            acc_v[e] = bus4.mem_busy && !prev_busy;
            prev_busy = bus4.mem_busy;
            if (e == 20) bus4.cache2mem_valid = 1'b0;
        end
        next_ok = 1;
        for (int e = 1; e <= 20; e++) begin
            if (e >= next_ok) begin
                exp_acc[e]        = 1'b1;
                exp_rdy[e + LAT4] = 1'b1;
                next_ok           = e + LAT4 + 2;
            end
        end
        last4 = model[blk(32'h0000_0010)];
        check("stream_accepts", 128'(acc_v), 128'(exp_acc));
        check("stream_readies", 128'(rdy_v), 128'(exp_rdy));
        check("stream_data",    bus4.mem2cache_data, last4);

        // Reset two cycles into a write aborts it
        d_old = rnd128();
        req4(1'b1, 32'h0000_3000, d_old, 1'b0, "wr_old");
        d_new = ~d_old;
        bus4.cache2mem_valid = 1'b1;
        bus4.cache2mem_rw    = 1'b1;
        bus4.cache2mem_addr  = 32'h0000_3000;
        bus4.cache2mem_data  = d_new;
        @(posedge clk);
        @(negedge clk);
        bus4.cache2mem_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        r = 1'b0;
        #1;
        check("abort_busy",  128'(bus4.mem_busy), 128'(0));
        check("abort_ready", 128'(bus4.mem2cache_ready), 128'(0));
        check("abort_data",  bus4.mem2cache_data, '0);
        last4 = '0;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.mem2cache_ready) pulses++;
            if (e == 2) r = 1'b1;
        end
        check("abort_no_ready", 128'(pulses), 128'(0));
        req4(1'b0, 32'h0000_3008, '0, 1'b0, "rd_after_abort");

        // LATENCY=1: back-to-back write then read of the same block
        d3 = rnd128();
        busy_v = '0; rdy_v = '0; exp_busy = '0; exp_rdy = '0;
        bus1.cache2mem_valid = 1'b1;
        bus1.cache2mem_rw    = 1'b1;
        bus1.cache2mem_addr  = 32'h0000_0450;
        bus1.cache2mem_data  = d3;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            busy_v[e] = bus1.mem_busy;
            rdy_v[e]  = bus1.mem2cache_ready;
            if (e == 1) begin
                bus1.cache2mem_rw   = 1'b0;
                bus1.cache2mem_addr = 32'h0000_045C;
                bus1.cache2mem_data = rnd128();
            end
            if (e == 1 + LAT1 + 2) bus1.cache2mem_valid = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            for (int e = 1 + k * (LAT1 + 2); e <= 1 + k * (LAT1 + 2) + LAT1; e++) exp_busy[e] = 1'b1;
            exp_rdy[1 + k * (LAT1 + 2) + LAT1] = 1'b1;
        end
        check("lat1_busy",  128'(busy_v), 128'(exp_busy));
        check("lat1_ready", 128'(rdy_v), 128'(exp_rdy));
        check("lat1_data",  bus1.mem2cache_data, d3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
